// File: rtl/video_field_gen.sv
// Raster timing generator: FRONT/ACTIVE/BACK lines, GAP between fields, test patterns.
// Outputs registered from next-state values (aligned to state); free-running, no backpressure.
module video_field_gen #(
  parameter int H_ACTIVE   = 702,
  parameter int V_LINES    = 288,
  parameter int N_FIELDS   = 2,
  parameter int PIX_PERIOD = 8,
  parameter int DV_OFFSET  = 2,
  parameter int H_FRONT    = 1500,
  parameter int H_BACK     = 1884,
  parameter int V_GAP      = 100000,
  parameter int DATA_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  output logic              video_frame_valid_o,
  output logic              video_line_valid_o,
  output logic              video_data_valid_o,
  output logic [DATA_W-1:0] video_data_o,
  output logic [19:0]       video_address_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CNT_MAX = (H_FRONT > H_BACK) ? ((H_FRONT > V_GAP) ? H_FRONT : V_GAP)
                                              : ((H_BACK  > V_GAP) ? H_BACK  : V_GAP);
  localparam int CNT_W  = (CNT_MAX > 1)    ? $clog2(CNT_MAX)    : 1;
  localparam int SLOT_W = (PIX_PERIOD > 1) ? $clog2(PIX_PERIOD) : 1;
  localparam int COL_W  = (H_ACTIVE > 1)   ? $clog2(H_ACTIVE)   : 1;
  localparam int ROW_W  = (V_LINES > 1)    ? $clog2(V_LINES)    : 1;

  generate
    if (N_FIELDS < 1 || N_FIELDS > 2) begin : g_bad_fields
      $error("N_FIELDS must be 1 or 2");
    end
    if (PIX_PERIOD < 2 || DV_OFFSET >= PIX_PERIOD) begin : g_bad_slot
      $error("PIX_PERIOD must be >= 2 and DV_OFFSET < PIX_PERIOD");
    end
    if (H_FRONT < 1 || H_BACK < 1 || V_GAP < 1 || H_ACTIVE < 1 || V_LINES < 1) begin : g_bad_timing
      $error("timing parameters must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    ACTIVE = 3'd2,
    BACK   = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                field_q, field_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   fcnt_q, fcnt_d;

  logic                fv_q, fv_d;
  logic                lv_q, lv_d;
  logic                dv_q, dv_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [19:0]         addr_q, addr_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [ROW_W-1:0]  r,
                                                input logic [COL_W-1:0]  c,
                                                input logic [DATA_W-1:0] fc);
    case (m)
      2'd0:    return DATA_W'(c);
      2'd1:    return DATA_W'(r);
      2'd2:    return ((((32'(r) ^ 32'(c)) >> 3) & 32'd1) != 32'd0) ? {DATA_W{1'b1}} : '0;
      default: return fc;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    col_d   = col_q;
    row_d   = row_q;
    field_d = field_q;
    mode_d  = mode_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = FRONT;
          cnt_d   = '0;
          slot_d  = '0;
          col_d   = '0;
          row_d   = '0;
          field_d = 1'b0;
          mode_d  = mode_i;
        end
      end
      FRONT: begin
        if (cnt_q == CNT_W'(H_FRONT - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          slot_d  = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (slot_q == SLOT_W'(PIX_PERIOD - 1)) begin
          slot_d = '0;
          // col is left on the last pixel so the address holds through blanking
          if (col_q == COL_W'(H_ACTIVE - 1)) begin
            state_d = BACK;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      BACK: begin
        if (cnt_q == CNT_W'(H_BACK - 1)) begin
          cnt_d = '0;
          if (row_q == ROW_W'(V_LINES - 1)) begin
            state_d = GAP;
          end else begin
            state_d = FRONT;
            row_d   = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(V_GAP - 1)) begin
          cnt_d = '0;
          row_d = '0;
          if (field_q == 1'(N_FIELDS - 1)) begin
            fcnt_d  = fcnt_q + 1'b1;
            field_d = 1'b0;
            if (enable_i) begin
              state_d = FRONT;
              mode_d  = mode_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = FRONT;
            field_d = 1'b1;
            mode_d  = mode_i;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers load from next-state values so they line up with state_q.
    fv_d   = (state_d == FRONT) || (state_d == ACTIVE) || (state_d == BACK);
    lv_d   = (state_d == ACTIVE);
    dv_d   = (state_d == ACTIVE) && (slot_d == SLOT_W'(DV_OFFSET));
    done_d = (state_d == GAP) && (cnt_d == CNT_W'(V_GAP - 1)) && (field_d == 1'(N_FIELDS - 1));
    busy_d = (state_d != IDLE);
    addr_d = addr_q;
    data_d = data_q;
    if (state_d == ACTIVE) begin
      if (slot_d == '0) begin
        addr_d = {9'(row_d), field_d, 10'(col_d)};
        data_d = pattern(mode_d, row_d, col_d, fcnt_d);
      end
    end else begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      field_q <= 1'b0;
      mode_q  <= 2'd0;
      fcnt_q  <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      row_q   <= row_d;
      field_q <= field_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign video_frame_valid_o = fv_q;
  assign video_line_valid_o  = lv_q;
  assign video_data_valid_o  = dv_q;
  assign video_data_o        = data_q;
  assign video_address_o     = addr_q;
  assign frame_done_o        = done_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_video_field_gen.sv
// Bench for video_field_gen with tiny timing parameters; a second instance uses DATA_W=2.
module tb_video_field_gen;

  localparam int EXP_LINE  = 16;  // H_ACTIVE*PIX_PERIOD
  localparam int EXP_FIELD = 42;  // 2*(3+16+2)
  localparam int EXP_GAP   = 5;
  localparam int EXP_FRAME = 94;  // 2*(42+5)

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;

  logic        vfv, vlv, vdv, vdone, vbusy;
  logic [7:0]  vdata;
  logic [19:0] vaddr;
  logic        d2_fv, d2_lv, d2_dv, d2_done, d2_busy;
  logic [1:0]  d2_data;
  logic [19:0] d2_addr;

  video_field_gen #(
    .H_ACTIVE(4), .V_LINES(2), .N_FIELDS(2), .PIX_PERIOD(4), .DV_OFFSET(1),
    .H_FRONT(3), .H_BACK(2), .V_GAP(5), .DATA_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
    .video_frame_valid_o(vfv), .video_line_valid_o(vlv), .video_data_valid_o(vdv),
    .video_data_o(vdata), .video_address_o(vaddr), .frame_done_o(vdone), .busy_o(vbusy)
  );

  video_field_gen #(
    .H_ACTIVE(4), .V_LINES(2), .N_FIELDS(2), .PIX_PERIOD(4), .DV_OFFSET(1),
    .H_FRONT(3), .H_BACK(2), .V_GAP(5), .DATA_W(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
    .video_frame_valid_o(d2_fv), .video_line_valid_o(d2_lv), .video_data_valid_o(d2_dv),
    .video_data_o(d2_data), .video_address_o(d2_addr), .frame_done_o(d2_done), .busy_o(d2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] cap_addr[$];
  logic [7:0]  cap_data[$];
  logic [1:0]  cap_d2[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected strobes for one frame; m0/m1 are the modes latched at each field start.
  task automatic add_frame(input int m0, input int m1, input int fc);
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          vec_t v;
          int   m;
          int   d;
          m = (f == 0) ? m0 : m1;
          case (m)
            0:       d = c;
            1:       d = r;
            2:       d = ((((r ^ c) >> 3) & 1) != 0) ? 255 : 0;
            default: d = fc % 256;
          endcase
          v.addr = {9'(r), 1'(f), 10'(c)};
          v.data = 8'(d);
          vecs.push_back(v);
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_frame_valid"}, 32'(vfv), 32'd0);
    chk({tag, "_line_valid"},  32'(vlv), 32'd0);
    chk({tag, "_data_valid"},  32'(vdv), 32'd0);
    chk({tag, "_data"},        32'(vdata), 32'd0);
    chk({tag, "_address"},     32'(vaddr), 32'd0);
    chk({tag, "_frame_done"},  32'(vdone), 32'd0);
    chk({tag, "_busy"},        32'(vbusy), 32'd0);
    chk({tag, "_data_w2"},     32'(d2_data), 32'd0);
  endtask

  // Runs one frame from the next clock until frame_done (or a cycle budget expires).
  task automatic run_frame(input int sw_at, input logic [1:0] sw_mode, input int en_off_at);
    int n, done_n, strobes, lines, fields, lv_len, lv_bad, fv_hi, fv_lo, fv_bad, dv_bad;
    n = 0; done_n = -1; strobes = 0; lines = 0; fields = 0; lv_len = 0;
    lv_bad = 0; fv_hi = 0; fv_lo = 0; fv_bad = 0; dv_bad = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      if (n > 0 || vfv) n++;
      if (n == sw_at) mode = sw_mode;
      if (n == en_off_at) enable = 1'b0;
      if (vlv) begin
        if (vdv !== ((lv_len % 4) == 1)) dv_bad++;
        lv_len++;
      end else begin
        if (lv_len != 0) begin
          lines++;
          if (lv_len != EXP_LINE) lv_bad++;
          lv_len = 0;
        end
        if (vdv !== 1'b0 || vdata !== 8'd0) dv_bad++;
      end
      if (vfv) begin
        if (fv_lo > 0) begin
          if (fv_lo != EXP_GAP) fv_bad++;
          fv_lo = 0;
        end
        fv_hi++;
      end else begin
        if (fv_hi > 0) begin
          fields++;
          if (fv_hi != EXP_FIELD) fv_bad++;
          fv_hi = 0;
        end
        if (n > 0) fv_lo++;
      end
      if (vdv) begin
        strobes++;
        cap_addr.push_back(vaddr);
        cap_data.push_back(vdata);
        cap_d2.push_back(d2_data);
      end
      if (vdone) begin
        if (fv_lo != EXP_GAP) fv_bad++;
        done_n = n;
        break;
      end
    end
    chk("frame_done_clock", 32'(done_n), 32'(EXP_FRAME));
    chk("strobes_per_frame", 32'(strobes), 32'd16);
    chk("lines_per_frame", 32'(lines), 32'd4);
    chk("line_valid_length_errs", 32'(lv_bad), 32'd0);
    chk("fields_per_frame", 32'(fields), 32'd2);
    chk("frame_valid_timing_errs", 32'(fv_bad), 32'd0);
    chk("data_valid_slot_errs", 32'(dv_bad), 32'd0);
  endtask

  initial begin
    int found;
    int seen_low;

    // Expected strobe stream, in the order the scenarios below produce it.
    for (int fr = 0; fr < 4; fr++) add_frame(fr, fr, fr);   // modes 0..3, counter 0..3
    add_frame(0, 1, 4);                                       // mode switch mid field 0
    for (int fr = 0; fr < 5; fr++) add_frame(3, 3, fr);       // counter 0..4 after reset
    add_frame(0, 0, 0);                                       // restart after reset

    rst = 1'b1; enable = 1'b0; mode = 2'd0;
    #12;
    check_reset("reset");
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("idle_busy", 32'(vbusy), 32'd0);
    chk("idle_frame_valid", 32'(vfv), 32'd0);

    // Four back-to-back frames, one mode each.
    for (int fr = 0; fr < 4; fr++) begin
      mode = 2'(fr);
      enable = 1'b1;
      run_frame(-1, 2'd0, -1);
    end

    // Enable drops early in field 0 and mode changes in field 0: frame completes, then IDLE.
    mode = 2'd0;
    run_frame(10, 2'd1, 5);
    step();
    chk("after_stop_busy", 32'(vbusy), 32'd0);
    chk("after_stop_frame_valid", 32'(vfv), 32'd0);
    chk("frame_done_one_clock", 32'(vdone), 32'd0);
    step(); step();
    chk("stays_idle_busy", 32'(vbusy), 32'd0);

    // Frame counter pattern after reset: 8-bit and 2-bit (wrapping) instances.
    #2 rst = 1'b1;
    #1 check_reset("reset2");
    step();
    rst = 1'b0;
    mode = 2'd3;
    enable = 1'b1;
    for (int fr = 0; fr < 5; fr++) run_frame(-1, 2'd0, -1);

    // Asynchronous reset during ACTIVE of field 1, then restart.
    mode = 2'd0;
    found = 0;
    seen_low = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      step();
      if (!vfv) seen_low = 1;
      if (seen_low != 0 && vlv) begin
        found = 1;
        break;
      end
    end
    chk("reach_field1_active", 32'(found), 32'd1);
    chk("field1_address_bit", 32'(vaddr[10]), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    step();
    rst = 1'b0;
    run_frame(-1, 2'd0, -1);

    chk("strobe_total", 32'(cap_addr.size()), 32'(vecs.size()));
    for (int i = 0; i < vecs.size() && i < cap_addr.size(); i++) begin
      chk($sformatf("addr[%0d]", i), 32'(cap_addr[i]), 32'(vecs[i].addr));
      chk($sformatf("data[%0d]", i), 32'(cap_data[i]), 32'(vecs[i].data));
      chk($sformatf("data_w2[%0d]", i), 32'(cap_d2[i]), 32'(vecs[i].data[1:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
